// File: rtl/axi_write_pkg.sv
// Types and default widths shared between the write-request buffer and the AXI-lite writer.
package axi_write_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/adam_seq.sv
// Sequencing bundle: the single clock and the asynchronous active-low reset.
interface ADAM_SEQ;
  logic clk;
  logic rst;

  modport Master (output clk, output rst);
  modport Slave  (input clk, input rst);
endinterface

// File: rtl/axi_write_fifo.sv
// In-order write-request buffer feeding the low-priority FSM port of the AXI-lite writer.
// The head entry is presented from registers and popped on the writer's ack pulse.
module axi_write_fifo
  import axi_write_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = AXI_ADDR_W,
  parameter int unsigned DATA_W = AXI_DATA_W
) (
  ADAM_SEQ.Slave                        seq_port,
  input  logic                          push_valid_i,
  output logic                          push_ready_o,
  input  logic [ADDR_W-1:0]             push_addr_i,
  input  logic [DATA_W-1:0]             push_data_i,
  output logic                          fsm_req_o,
  output logic [ADDR_W-1:0]             fsm_adress_o,
  output logic [DATA_W-1:0]             fsm_data_o,
  input  logic                          fsm_ack_i,
  input  logic                          flush_i,
  output logic [$clog2(DEPTH+1)-1:0]    count_o,
  output logic                          overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic               ovf_q,    ovf_d;
  logic               push_fire, pop_fire;

  // A pop never frees space for a same-cycle push: readiness comes from count alone.
  assign push_ready_o = (count_q != CNT_W'(DEPTH));
  assign push_fire    = push_valid_i && push_ready_o;
  assign pop_fire     = fsm_ack_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_fire, pop_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (push_valid_i && !push_ready_o) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge seq_port.clk or negedge seq_port.rst) begin
    if (!seq_port.rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is left untouched by flush; only the pointers forget it.
  always_ff @(posedge seq_port.clk or negedge seq_port.rst) begin
    if (!seq_port.rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (!flush_i && push_fire) begin
      mem_q[wr_ptr_q] <= '{addr: push_addr_i, data: push_data_i};
    end
  end

  assign fsm_req_o    = (count_q != '0);
  assign fsm_adress_o = mem_q[rd_ptr_q].addr;
  assign fsm_data_o   = mem_q[rd_ptr_q].data;
  assign count_o      = count_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_axi_write_fifo.sv
// Randomised and directed bench for axi_write_fifo against a queue-based reference model.
module tb_axi_write_fifo;
  import axi_write_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push_valid, push_ready;
  logic [31:0] push_addr, push_data;
  logic        fsm_req, fsm_ack, flush, overflow;
  logic [31:0] fsm_adress, fsm_data;
  logic [2:0]  count;

  ADAM_SEQ seq ();
  assign seq.clk = clk;
  assign seq.rst = rst_n;

  axi_write_fifo #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .seq_port     (seq),
    .push_valid_i (push_valid),
    .push_ready_o (push_ready),
    .push_addr_i  (push_addr),
    .push_data_i  (push_data),
    .fsm_req_o    (fsm_req),
    .fsm_adress_o (fsm_adress),
    .fsm_data_o   (fsm_data),
    .fsm_ack_i    (fsm_ack),
    .flush_i      (flush),
    .count_o      (count),
    .overflow_o   (overflow)
  );

  always #5 clk = ~clk;

  wr_req_t mq[$];
  logic    m_ovf;
  int      n_vec = 0;
  int      n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".count"}, 64'(count), 64'(mq.size()));
    check_eq({tag, ".req"},   64'(fsm_req), 64'(mq.size() != 0));
    check_eq({tag, ".ready"}, 64'(push_ready), 64'(mq.size() != DEPTH));
    check_eq({tag, ".ovf"},   64'(overflow), 64'(m_ovf));
    if (mq.size() != 0) begin
      check_eq({tag, ".addr"}, 64'(fsm_adress), 64'(mq[0].addr));
      check_eq({tag, ".data"}, 64'(fsm_data),   64'(mq[0].data));
    end
  endtask

  // Called at a falling edge: apply inputs, advance the model over the rising edge, check.
  task automatic step(input string tag, input logic pv, input logic [31:0] a, input logic [31:0] d,
                      input logic ack, input logic fl);
    logic room;
    push_valid = pv; push_addr = a; push_data = d; fsm_ack = ack; flush = fl;
    @(posedge clk);
    room = (mq.size() != DEPTH);
    if (fl) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (pv && !room) m_ovf = 1'b1;
      if (ack && mq.size() != 0) void'(mq.pop_front());
      if (pv && room) mq.push_back('{addr: a, data: d});
    end
    @(negedge clk);
    push_valid = 1'b0; fsm_ack = 1'b0; flush = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1);
  end

  initial begin
    push_valid = 1'b0; push_addr = '0; push_data = '0; fsm_ack = 1'b0; flush = 1'b0;
    m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs("reset");
    check_eq("reset.addr0", 64'(fsm_adress), 64'h0);
    check_eq("reset.data0", 64'(fsm_data), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single entry into empty buffer, held without ack.
    step("push1", 1'b1, 32'h4000_0000, 32'hDEAD_BEEF, 1'b0, 1'b0);
    repeat (3) step("hold", 1'b0, '0, '0, 1'b0, 1'b0);
    step("pop1", 1'b0, '0, '0, 1'b1, 1'b0);

    // Fill, overflow, drain in order.
    for (int i = 0; i < 4; i++) step("fill", 1'b1, 32'hA000 + i, 32'hD000 + i, 1'b0, 1'b0);
    step("ovf", 1'b1, 32'h10, 32'h55, 1'b0, 1'b0);
    step("ovf_pop_full", 1'b1, 32'h11, 32'h66, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("drain", 1'b0, '0, '0, 1'b1, 1'b0);
    step("ack_empty", 1'b0, '0, '0, 1'b1, 1'b0);
    step("ack_empty2", 1'b0, '0, '0, 1'b1, 1'b0);

    // Simultaneous push/pop at count 2 across pointer wrap.
    step("pre2a", 1'b1, 32'hB000, 32'hE000, 1'b0, 1'b0);
    step("pre2b", 1'b1, 32'hB001, 32'hE001, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("pushpop", 1'b1, 32'hC000 + i, 32'hF000 + i, 1'b1, 1'b0);
    step("pre3", 1'b1, 32'hC100, 32'hF100, 1'b0, 1'b0);

    // Flush beats a same-cycle push and ack, then clears overflow.
    step("flush", 1'b1, 32'h99, 32'h99, 1'b1, 1'b1);
    step("post_flush", 1'b1, 32'h20, 32'h1, 1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(99) < 60), $urandom, $urandom,
           ($urandom_range(99) < 40), ($urandom_range(99) < 3));

    // Asynchronous reset mid-stream with two entries held.
    step("pre_rst_flush", 1'b0, '0, '0, 1'b0, 1'b1);
    step("pre_rst_a", 1'b1, 32'h123, 32'h456, 1'b0, 1'b0);
    step("pre_rst_b", 1'b1, 32'h789, 32'hABC, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    mq.delete();
    m_ovf = 1'b0;
    check_outputs("async_rst");
    check_eq("async_rst.addr0", 64'(fsm_adress), 64'h0);
    check_eq("async_rst.data0", 64'(fsm_data), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step("after_rst", 1'b1, 32'h300, 32'h400, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_write_fifo.md
Name: axi_write_fifo

Overview:
- Request buffer directly upstream of the AXI-lite write stage, on its low-priority FSM port.
- Accepts address/data write requests from the control FSM through a valid/ready push interface, stores them in order, and presents the head entry on the writer's fsm_req/fsm_adress/fsm_data inputs.
- Pops the head on the writer's one-cycle fsm_ack pulse, so the FSM never stalls on a single outstanding AXI write.
- Reports occupancy and a sticky overflow flag.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- ADDR_W, 32, write address width.
- DATA_W, 32, write data width.

Ports:
- seq_port.clk  input  1  single clock, carried on the ADAM_SEQ.Slave interface seq_port.
- seq_port.rst  input  1  reset on seq_port; asynchronous, active-low.
- push_valid_i  input  1  FSM presents a write request.
- push_ready_o  output  1  buffer can accept; equals not-full.
- push_addr_i  input  ADDR_W  request address.
- push_data_i  input  DATA_W  request data.
- fsm_req_o  output  1  head entry valid; drives the writer's fsm_req_i.
- fsm_adress_o  output  ADDR_W  head address; drives fsm_adress_i.
- fsm_data_o  output  DATA_W  head data; drives fsm_data_i.
- fsm_ack_i  input  1  writer accepted the head; one-cycle pulse.
- flush_i  input  1  synchronous discard of all entries.
- count_o  output  $clog2(DEPTH+1)  current occupancy.
- overflow_o  output  1  sticky; a push was attempted while full.

Behaviour:
- Reset (asynchronous assert, synchronous release): wr_ptr=0, rd_ptr=0, count=0, all storage entries=0, overflow_o=0. Resulting outputs: fsm_req_o=0, fsm_adress_o=0, fsm_data_o=0, push_ready_o=1, count_o=0.
- Storage:
  - DEPTH-entry register array of {addr, data}.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - count is tracked separately and distinguishes full from empty.
- Push:
  - Fires when push_valid_i && push_ready_o.
  - Writes mem[wr_ptr] and increments wr_ptr at the clock edge.
  - push_ready_o = (count != DEPTH), combinational from count. Pop does not bypass into a full buffer: a push in the same cycle as a pop while full is refused.
- Head outputs:
  - fsm_req_o = (count != 0); fsm_adress_o/fsm_data_o = mem[rd_ptr].
  - All are driven only from registers; no combinational path from push inputs.
  - Latency: a push into an empty buffer at edge N raises fsm_req_o after edge N.
- Pop:
  - Fires when fsm_ack_i && count != 0; increments rd_ptr.
  - fsm_req_o and the head fields stay stable from assertion until the edge on which the ack is sampled.
  - fsm_ack_i while empty is ignored; no pointer or count change.
- The writer captures at edge N and pulses ack during cycle N+1. The pop at edge N+1 presents the next entry from N+1 onward, before the writer can capture again, so no entry is issued twice.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together (0 < count < DEPTH): unchanged, both pointers advance.
- Full: push_ready_o=0 while count==DEPTH.
- Overflow:
  - push_valid_i && !push_ready_o sets overflow_o at the next edge. The request is dropped and the buffer is unaltered.
  - overflow_o is cleared only by reset or flush_i.
- flush_i:
  - Highest priority; a push or ack in the same cycle is discarded.
  - Next cycle: pointers=0, count=0, overflow_o=0, fsm_req_o=0. Storage contents are not cleared.
- Reset mid-operation: all state returns to reset values immediately; in-flight entries are lost.

Decomposition:
- Shared package (axi_write_pkg):
  - wr_req_t packed struct {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;}.
  - Default width constants AXI_ADDR_W=32, AXI_DATA_W=32, shared with the writer.
- No sub-module: storage, pointers and count fit in one module. Reuse a generic sync_fifo only if the team adds one later.

Test Plan:
- Reset with seq_port.rst=0 mid-stream (count=2) -> count_o=0, fsm_req_o=0, push_ready_o=1, overflow_o=0, asynchronously before the next edge.
- Push {0x4000_0000, 0xDEAD_BEEF} into empty, no ack -> fsm_req_o=1 one cycle later, fsm_adress_o/fsm_data_o hold those values indefinitely, count_o=1.
- Push 4 entries A0..A3 (DEPTH=4), then a 5th {0x10, 0x55} -> push_ready_o=0, overflow_o=1, count_o=4. Four ack pulses then pop A0..A3 in order; 0x10 never appears.
- Push and ack in the same cycle at count=2 -> count_o stays 2, head advances to the next entry. 10 push/pop cycles exercise pointer wrap; order is preserved.
- Ack pulse while empty -> no change; count_o=0, no underflow, fsm_req_o=0.
- flush_i asserted with count=3 together with push_valid_i and fsm_ack_i -> next cycle count_o=0, fsm_req_o=0, overflow_o=0; a subsequent push of {0x20, 0x1} appears as head.
